// File: rtl/fp_window_accum.sv
`default_nettype none
// ============================================================================
// Module   : fp_window_accum
// Purpose  : Decodes 8-bit FP codes (S,E[2:0],F[3:0]) to signed linear values
//            and sums WINDOW of them (or a flushed partial block) per result.
// Config   : define FPACC_SAT_EN to clamp the running sum instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module fp_window_accum #(
  parameter int WINDOW = 8,
  parameter int SUM_W  = 14,
  localparam int CNT_W = $clog2(WINDOW + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              in_fp,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  output logic signed [SUM_W-1:0] out_sum,
  output logic [CNT_W-1:0]        out_count,
  output logic                    out_ovf,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam logic [0:0] c_ACC = 1'b0;
  localparam logic [0:0] c_OUT = 1'b1;

  localparam logic [SUM_W-1:0] c_MAX = {1'b0, {(SUM_W-1){1'b1}}};
  localparam logic [SUM_W-1:0] c_MIN = {1'b1, {(SUM_W-1){1'b0}}};

  logic [0:0]       r_state;
  logic [SUM_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_flag;

  logic [10:0]      w_mag;
  logic [SUM_W:0]   w_mag_ext;
  logic [SUM_W:0]   w_dec;
  logic [SUM_W:0]   w_sum;
  logic             w_ovf;
  logic [SUM_W-1:0] w_acc_add;
  logic             w_accept;
  logic [SUM_W-1:0] w_acc_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_flag_nxt;
  logic             w_close;

  assign in_ready  = (r_state == c_ACC);
  assign out_valid = (r_state == c_OUT);
  assign w_accept  = in_valid && (r_state == c_ACC);

  // Negative zero needs no special case: -0 is 0 in two's complement.
  assign w_mag     = 11'(in_fp[3:0]) << in_fp[6:4];
  assign w_mag_ext = {{(SUM_W-10){1'b0}}, w_mag};
  assign w_dec     = in_fp[7] ? -w_mag_ext : w_mag_ext;

  // |dec| <= 1920 < 2^(SUM_W-1), so one guard bit holds the exact sum.
  assign w_sum = {r_acc[SUM_W-1], r_acc} + w_dec;
  assign w_ovf = w_sum[SUM_W] ^ w_sum[SUM_W-1];

  always_comb begin
    w_acc_add = w_sum[SUM_W-1:0];
`ifdef FPACC_SAT_EN
    if (w_ovf) begin
      w_acc_add = w_sum[SUM_W] ? c_MIN : c_MAX;
    end
`endif
  end

  assign w_acc_nxt  = w_accept ? w_acc_add : r_acc;
  assign w_cnt_nxt  = w_accept ? (r_cnt + CNT_W'(1)) : r_cnt;
  assign w_flag_nxt = r_flag | (w_accept & w_ovf);

  assign w_close = (w_accept && (w_cnt_nxt == CNT_W'(WINDOW))) ||
                   (flush && (r_state == c_ACC) && ((r_cnt != '0) || w_accept));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= c_ACC;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_flag    <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else begin
      case (r_state)
        c_ACC: begin
          if (w_close) begin
            r_state   <= c_OUT;
            out_sum   <= w_acc_nxt;
            out_count <= w_cnt_nxt;
            out_ovf   <= w_flag_nxt;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_flag    <= 1'b0;
          end else begin
            r_acc     <= w_acc_nxt;
            r_cnt     <= w_cnt_nxt;
            r_flag    <= w_flag_nxt;
          end
        end
        c_OUT: begin
          if (out_ready) begin
            r_state <= c_ACC;
          end
        end
        default: r_state <= c_ACC;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fp_window_accum.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_window_accum
// Purpose  : Directed and random stimulus for fp_window_accum, checked every
//            cycle against a block-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_window_accum;

  localparam int WINDOW = 8;
  localparam int SUM_W  = 14;
  localparam int CNT_W  = $clog2(WINDOW + 1);
  localparam int c_MAX  = (1 << (SUM_W - 1)) - 1;
  localparam int c_MIN  = -(1 << (SUM_W - 1));
  localparam int c_MOD  = 1 << SUM_W;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic [7:0]              in_fp = '0;
  logic                    in_valid = 1'b0;
  logic                    in_ready;
  logic                    flush = 1'b0;
  logic signed [SUM_W-1:0] out_sum;
  logic [CNT_W-1:0]        out_count;
  logic                    out_ovf;
  logic                    out_valid;
  logic                    out_ready = 1'b0;

  fp_window_accum #(.WINDOW(WINDOW), .SUM_W(SUM_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_fp    (in_fp),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .flush    (flush),
    .out_sum  (out_sum),
    .out_count(out_count),
    .out_ovf  (out_ovf),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: pending samples of the open block plus the last result.
  bit m_out;
  int m_q[$];
  int m_sum;
  int m_cnt;
  bit m_ovf;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int fp_decode(input logic [7:0] c);
    int mag;
    mag = int'(c[3:0]) * (1 << int'(c[6:4]));
    return c[7] ? -mag : mag;
  endfunction

  task automatic model_reset();
    m_out = 1'b0;
    m_q.delete();
    m_sum = 0;
    m_cnt = 0;
    m_ovf = 1'b0;
  endtask

  task automatic close_block();
    int a;
    int t;
    bit o;
    a = 0;
    o = 1'b0;
    foreach (m_q[i]) begin
      t = a + m_q[i];
      if (t > c_MAX || t < c_MIN) begin
        o = 1'b1;
`ifdef FPACC_SAT_EN
        t = (t > c_MAX) ? c_MAX : c_MIN;
`else
        t = (((t - c_MIN) % c_MOD) + c_MOD) % c_MOD + c_MIN;
`endif
      end
      a = t;
    end
    m_sum = a;
    m_cnt = m_q.size();
    m_ovf = o;
    m_q.delete();
    m_out = 1'b1;
  endtask

  task automatic check_all();
    chk("in_ready",  in_ready,  !m_out);
    chk("out_valid", out_valid, m_out);
    chk("out_sum",   out_sum,   m_sum);
    chk("out_count", out_count, m_cnt);
    chk("out_ovf",   out_ovf,   m_ovf);
  endtask

  task automatic cyc(input bit v, input logic [7:0] fp, input bit fl, input bit ordy);
    in_valid  = v;
    in_fp     = fp;
    flush     = fl;
    out_ready = ordy;
    @(posedge clk);
    if (!m_out) begin
      if (v) m_q.push_back(fp_decode(fp));
      if (m_q.size() == WINDOW || (fl && m_q.size() > 0)) close_block();
    end else if (ordy) begin
      m_out = 1'b0;
    end
    #1;
    check_all();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Full block of +52s
    repeat (WINDOW) cyc(1'b1, 8'h2D, 1'b0, 1'b0);
    chk("blk_sum", out_sum, 416);
    chk("blk_cnt", out_count, 8);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);

    // Alternating +30/-30, then negative zeros
    for (int i = 0; i < WINDOW; i++) cyc(1'b1, (i % 2) ? 8'h9F : 8'h1F, 1'b0, 1'b0);
    chk("mix_sum", out_sum, 0);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    repeat (WINDOW) cyc(1'b1, 8'h80, 1'b0, 1'b0);
    chk("negz_sum", out_sum, 0);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);

    // Overflow
    repeat (WINDOW) cyc(1'b1, 8'h7F, 1'b0, 1'b0);
`ifdef FPACC_SAT_EN
    chk("ovf_sum", out_sum, 8191);
`else
    chk("ovf_sum", out_sum, -1024);
`endif
    chk("ovf_flag", out_ovf, 1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);

    // Flush partial block, flush when empty, flush on closing accept
    repeat (3) cyc(1'b1, 8'h11, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("flush_sum", out_sum, 6);
    chk("flush_cnt", out_count, 3);
    cyc(1'b0, 8'h00, 1'b1, 1'b1);
    repeat (2) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("flush_empty_valid", out_valid, 0);
    repeat (WINDOW - 1) cyc(1'b1, 8'h11, 1'b0, 1'b0);
    cyc(1'b1, 8'h11, 1'b1, 1'b0);
    chk("flush_last_cnt", out_count, 8);
    cyc(1'b0, 8'h00, 1'b1, 1'b1);
    chk("flush_last_single", out_valid, 0);

    // Backpressure with a held sample
    repeat (WINDOW) cyc(1'b1, 8'h01, 1'b0, 1'b0);
    repeat (5) cyc(1'b1, 8'h01, 1'b0, 1'b0);
    cyc(1'b1, 8'h01, 1'b0, 1'b1);
    repeat (WINDOW) cyc(1'b1, 8'h01, 1'b0, 1'b1);
    chk("bp_next_sum", out_sum, 8);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);

    // Asynchronous reset mid-window
    repeat (4) cyc(1'b1, 8'h7F, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (WINDOW) cyc(1'b1, 8'h01, 1'b0, 1'b0);
    chk("rst_sum", out_sum, 8);
    chk("rst_cnt", out_count, 8);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 15) == 0,
          $urandom_range(0, 2) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
